// File: rtl/config_regfile_pkg.sv
// Shared types and constants for the DDR controller configuration register file.
// Register 0 carries the burst-size field consumed by the controller core.
package config_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } cfg_state_t;

  localparam int unsigned BYTES_PER_REG  = 8;
  localparam int unsigned BURST_SIZE_LSB = 0;
  localparam int unsigned BURST_SIZE_W   = 2;

endpackage

// File: rtl/config_regfile_if.sv
// Host-side write-burst and read-back bus of the configuration register file.
// The decoder is the master; the register file is the slave.
interface config_regfile_if #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 64,
  parameter int BURST_W = 3
);
  logic              config_wstrobe;
  logic [ADDR_W-1:0] waddr;
  logic [BURST_W-1:0] wburst;
  logic [DATA_W-1:0] wdata;
  logic              wdone;
  logic              werr;
  logic              config_rstrobe;
  logic [ADDR_W-1:0] raddr;
  logic              rvalid;
  logic              rerr;
  logic [DATA_W-1:0] rdata;

  modport master (
    output config_wstrobe, waddr, wburst, wdata, config_rstrobe, raddr,
    input  wdone, werr, rvalid, rerr, rdata
  );

  modport slave (
    input  config_wstrobe, waddr, wburst, wdata, config_rstrobe, raddr,
    output wdone, werr, rvalid, rerr, rdata
  );
endinterface

// File: rtl/config_regfile_read_port.sv
// Registered read-back of the live registers; one-cycle latency, rdata forced
// to zero on a misaligned or out-of-range address.
module config_read_port
  import config_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rstrobe,
  input  logic [ADDR_W-1:0]          raddr,
  input  logic [NUM_REGS*DATA_W-1:0] regs,
  output logic                       rvalid,
  output logic                       rerr,
  output logic [DATA_W-1:0]          rdata
);
  localparam int OFF_W = $clog2(BYTES_PER_REG);
  localparam int IDX_W = ADDR_W - OFF_W;

  logic              hit_s;
  logic              misal_s;
  logic [DATA_W-1:0] sel_s;

  // Address decode: one-hot match folded into a mux so no index can run off the array.
  always_comb begin
    hit_s   = 1'b0;
    sel_s   = {DATA_W{1'b0}};
    misal_s = (raddr[OFF_W-1:0] != {OFF_W{1'b0}});
    for (int i = 0; i < NUM_REGS; i++) begin
      hit_s = hit_s | (raddr[ADDR_W-1:OFF_W] == IDX_W'(i));
      sel_s = sel_s | (regs[i*DATA_W +: DATA_W] &
                       {DATA_W{raddr[ADDR_W-1:OFF_W] == IDX_W'(i)}});
    end
  end

  // Registered read response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid <= 1'b0;
      rerr   <= 1'b0;
      rdata  <= {DATA_W{1'b0}};
    end else begin
      rvalid <= rstrobe;
      if (rstrobe) begin
        if (misal_s || !hit_s) begin
          rerr  <= 1'b1;
          rdata <= {DATA_W{1'b0}};
        end else begin
          rerr  <= 1'b0;
          rdata <= sel_s;
        end
      end else begin
        rerr <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/config_regfile.sv
// Configuration register file: multi-beat write bursts staged in a shadow
// buffer and committed atomically on the final beat, plus a read-back port.
module config_regfile
  import config_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 8,
  parameter int BURST_W  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  config_regfile_if.slave            bus,
  output logic [NUM_REGS*DATA_W-1:0] cfg_regs,
  output logic [1:0]                 burst_size,
  output logic [NUM_REGS-1:0]        config_update
);
  localparam int OFF_W = $clog2(BYTES_PER_REG);
  localparam int IDX_W = ADDR_W - OFF_W;
  localparam int SUM_W = ((IDX_W > BURST_W) ? IDX_W : BURST_W) + 2;
  localparam logic [BURST_W-1:0] CNT_ONE = {{(BURST_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]   IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0]   regs_r   [NUM_REGS];
  logic [DATA_W-1:0]   shadow_r [NUM_REGS];
  cfg_state_t          state_r;
  logic [BURST_W-1:0]  cnt_r;
  logic [IDX_W-1:0]    base_r;
  logic [IDX_W-1:0]    wr_idx_r;
  logic                wdone_r;
  logic                werr_r;
  logic [NUM_REGS-1:0] update_r;

  logic [IDX_W-1:0] first_idx_s;
  logic [SUM_W-1:0] end_s;
  logic             bad_s;
  logic             single_s;

  // First-beat decode: start index, end index and error condition.
  always_comb begin
    first_idx_s = bus.waddr[ADDR_W-1:OFF_W];
    end_s       = SUM_W'(first_idx_s) + SUM_W'(bus.wburst) + SUM_W'(1'b1);
    single_s    = (bus.wburst == {BURST_W{1'b0}});
    bad_s       = (bus.waddr[OFF_W-1:0] != {OFF_W{1'b0}}) || (end_s > SUM_W'(NUM_REGS));
  end

  // Write FSM: shadow staging, atomic commit, and registered response pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= {BURST_W{1'b0}};
      base_r   <= {IDX_W{1'b0}};
      wr_idx_r <= {IDX_W{1'b0}};
      wdone_r  <= 1'b0;
      werr_r   <= 1'b0;
      update_r <= {NUM_REGS{1'b0}};
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i]   <= {DATA_W{1'b0}};
        shadow_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      wdone_r  <= 1'b0;
      werr_r   <= 1'b0;
      update_r <= {NUM_REGS{1'b0}};
      case (state_r)
        IDLE: begin
          if (bus.config_wstrobe) begin
            cnt_r <= bus.wburst;
            if (bad_s) begin
              if (single_s) begin
                wdone_r <= 1'b1;
                werr_r  <= 1'b1;
              end else begin
                state_r <= DRAIN;
              end
            end else if (single_s) begin
              wdone_r <= 1'b1;
              for (int i = 0; i < NUM_REGS; i++) begin
                if (IDX_W'(i) == first_idx_s) begin
                  regs_r[i]   <= bus.wdata;
                  update_r[i] <= 1'b1;
                end
              end
            end else begin
              base_r   <= first_idx_s;
              wr_idx_r <= first_idx_s + IDX_ONE;
              state_r  <= BURST;
              for (int i = 0; i < NUM_REGS; i++) begin
                if (IDX_W'(i) == first_idx_s) begin
                  shadow_r[i] <= bus.wdata;
                end
              end
            end
          end
        end
        BURST: begin
          if (bus.config_wstrobe) begin
            if (cnt_r == CNT_ONE) begin
              // Earlier beats come from the shadow, the final beat straight from wdata.
              wdone_r <= 1'b1;
              state_r <= IDLE;
              for (int i = 0; i < NUM_REGS; i++) begin
                if (IDX_W'(i) >= base_r && IDX_W'(i) < wr_idx_r) begin
                  regs_r[i]   <= shadow_r[i];
                  update_r[i] <= 1'b1;
                end else if (IDX_W'(i) == wr_idx_r) begin
                  regs_r[i]   <= bus.wdata;
                  update_r[i] <= 1'b1;
                end
              end
            end else begin
              wr_idx_r <= wr_idx_r + IDX_ONE;
              cnt_r    <= cnt_r - CNT_ONE;
              for (int i = 0; i < NUM_REGS; i++) begin
                if (IDX_W'(i) == wr_idx_r) begin
                  shadow_r[i] <= bus.wdata;
                end
              end
            end
          end
        end
        DRAIN: begin
          if (bus.config_wstrobe) begin
            if (cnt_r == CNT_ONE) begin
              wdone_r <= 1'b1;
              werr_r  <= 1'b1;
              state_r <= IDLE;
            end else begin
              cnt_r <= cnt_r - CNT_ONE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign cfg_regs[g*DATA_W +: DATA_W] = regs_r[g];
  end

  assign burst_size    = regs_r[0][BURST_SIZE_LSB +: BURST_SIZE_W];
  assign config_update = update_r;
  assign bus.wdone     = wdone_r;
  assign bus.werr      = werr_r;

  config_read_port #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W)
  ) u_read_port (
    .clk     (clk),
    .rst     (rst),
    .rstrobe (bus.config_rstrobe),
    .raddr   (bus.raddr),
    .regs    (cfg_regs),
    .rvalid  (bus.rvalid),
    .rerr    (bus.rerr),
    .rdata   (bus.rdata)
  );
endmodule

// File: tb/tb_config_regfile.sv
// Scoreboard bench for config_regfile: expected write/read responses are queued
// as stimulus is driven and compared when wdone/rvalid appear.
module tb_config_regfile;
  logic         clk;
  logic         rst;
  logic [255:0] cfg_regs;
  logic [1:0]   burst_size;
  logic [3:0]   config_update;

  config_regfile_if #(.ADDR_W(8), .DATA_W(64), .BURST_W(3)) bus ();

  config_regfile #(.NUM_REGS(4), .DATA_W(64), .ADDR_W(8), .BURST_W(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .cfg_regs      (cfg_regs),
    .burst_size    (burst_size),
    .config_update (config_update)
  );

  typedef struct {
    logic         werr;
    logic [3:0]   upd;
    logic [255:0] regs;
  } wexp_t;

  typedef struct {
    logic        rerr;
    logic [63:0] data;
  } rexp_t;

  wexp_t       wq[$];
  rexp_t       rq[$];
  logic [63:0] m_regs[4];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mflat();
    logic [255:0] f;
    for (int i = 0; i < 4; i++) f[i*64 +: 64] = m_regs[i];
    return f;
  endfunction

  function automatic rexp_t read_model(input logic [7:0] addr);
    rexp_t r;
    if (addr[2:0] != 3'd0 || addr[7:3] >= 5'd4) begin
      r.rerr = 1'b1;
      r.data = 64'd0;
    end else begin
      r.rerr = 1'b0;
      r.data = m_regs[addr[4:3]];
    end
    return r;
  endfunction

  // Drive one burst; optional read on the final beat; hold-checks during the burst.
  task automatic do_burst(input logic [7:0] addr, input int nbeats,
                          input logic [63:0] d0, input logic [63:0] d1,
                          input logic [63:0] d2, input logic [63:0] d3,
                          input int stall, input bit rd_en, input logic [7:0] rd_addr);
    logic [63:0] d[4];
    wexp_t       e;
    bit          bad;
    int          idx;
    d   = '{d0, d1, d2, d3};
    idx = int'(addr) / 8;
    bad = (addr[2:0] != 3'd0) || (idx + nbeats > 4);
    for (int b = 0; b < nbeats; b++) begin
      bus.config_wstrobe = 1'b1;
      bus.wdata          = d[b];
      if (b == 0) begin
        bus.waddr  = addr;
        bus.wburst = 3'(nbeats - 1);
      end else begin
        bus.waddr  = 8'($urandom);
        bus.wburst = 3'($urandom);
      end
      if (b == nbeats - 1) begin
        if (rd_en) begin
          rq.push_back(read_model(rd_addr));
          bus.config_rstrobe = 1'b1;
          bus.raddr          = rd_addr;
        end
        e.werr = bad;
        e.upd  = 4'd0;
        if (!bad) begin
          for (int k = 0; k < nbeats; k++) begin
            m_regs[idx + k] = d[k];
            e.upd[idx + k]  = 1'b1;
          end
        end
        e.regs = mflat();
        wq.push_back(e);
      end
      @(negedge clk);
      bus.config_rstrobe = 1'b0;
      if (b != nbeats - 1) begin
        bus.config_wstrobe = 1'b0;
        check_val("hold", cfg_regs, mflat());
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          check_val("hold_stall", cfg_regs, mflat());
        end
      end
    end
    bus.config_wstrobe = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] addr);
    rq.push_back(read_model(addr));
    bus.config_rstrobe = 1'b1;
    bus.raddr          = addr;
    @(negedge clk);
    bus.config_rstrobe = 1'b0;
  endtask

  // Response monitor: pop the scoreboard on every wdone/rvalid, flag stray pulses.
  always @(negedge clk) begin
    wexp_t we;
    rexp_t re;
    if (!rst) begin
      if (bus.wdone) begin
        if (wq.size() == 0) begin
          check_val("wdone_unexpected", 256'(bus.wdone), 256'(0));
        end else begin
          we = wq.pop_front();
          check_val("werr", 256'(bus.werr), 256'(we.werr));
          check_val("config_update", 256'(config_update), 256'(we.upd));
          check_val("cfg_regs", cfg_regs, we.regs);
        end
      end else if (config_update != 4'd0) begin
        check_val("update_stray", 256'(config_update), 256'(0));
      end
      if (bus.rvalid) begin
        if (rq.size() == 0) begin
          check_val("rvalid_unexpected", 256'(bus.rvalid), 256'(0));
        end else begin
          re = rq.pop_front();
          check_val("rerr", 256'(bus.rerr), 256'(re.rerr));
          check_val("rdata", 256'(bus.rdata), 256'(re.data));
        end
      end
    end
  end

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    bus.config_wstrobe = 1'b0;
    bus.waddr          = 8'd0;
    bus.wburst         = 3'd0;
    bus.wdata          = 64'd0;
    bus.config_rstrobe = 1'b0;
    bus.raddr          = 8'd0;
    for (int i = 0; i < 4; i++) m_regs[i] = 64'd0;
    repeat (3) @(negedge clk);
    check_val("rst_regs", cfg_regs, 256'd0);
    check_val("rst_wdone", 256'(bus.wdone), 256'(0));
    check_val("rst_rvalid", 256'(bus.rvalid), 256'(0));
    rst = 1'b0;
    @(negedge clk);

    // Single-beat write, same shape as the old one-register block.
    do_burst(8'd0, 1, 64'd2, 64'd0, 64'd0, 64'd0, 0, 1'b0, 8'd0);
    check_val("burst_size", 256'(burst_size), 256'(2));
    check_val("wdone_latency", 256'(bus.wdone), 256'(1));

    // Three beats into regs 1..3 with stalls between beats.
    do_burst(8'd8, 3, 64'hAAAA_0001_0000_000A, 64'hBBBB_0002_0000_000B,
             64'hCCCC_0003_0000_000C, 64'd0, 2, 1'b0, 8'd0);
    @(negedge clk);

    // Overrun burst absorbed via DRAIN, then a misaligned single beat.
    do_burst(8'd16, 4, 64'h11, 64'h22, 64'h33, 64'h44, 1, 1'b0, 8'd0);
    do_burst(8'd3, 1, 64'h55, 64'd0, 64'd0, 64'd0, 0, 1'b0, 8'd0);
    do_read(8'd3);
    do_read(8'd32);

    // Read of reg1 on the commit edge returns the old value; the next read the new one.
    do_burst(8'd8, 1, 64'hDDDD_0004_0000_000D, 64'd0, 64'd0, 64'd0, 0, 1'b1, 8'd8);
    do_read(8'd8);
    do_read(8'd24);

    // Back-to-back bursts with no bubble, then an aligned full-range burst.
    do_burst(8'd0, 2, 64'h0000_0000_0000_0003, 64'h1234_5678_9ABC_DEF0, 64'd0, 64'd0, 0, 1'b0, 8'd0);
    do_burst(8'd24, 1, 64'hFEED_FACE_CAFE_BEEF, 64'd0, 64'd0, 64'd0, 0, 1'b0, 8'd0);
    do_burst(8'd0, 4, 64'h1, 64'h2, 64'h3, 64'h4, 0, 1'b1, 8'd16);
    check_val("burst_size_b2b", 256'(burst_size), 256'(1));

    // Reset after 2 of 4 beats discards the burst.
    bus.config_wstrobe = 1'b1;
    bus.waddr          = 8'd0;
    bus.wburst         = 3'd3;
    bus.wdata          = 64'h77;
    @(negedge clk);
    bus.wdata = 64'h88;
    @(negedge clk);
    bus.config_wstrobe = 1'b0;
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) m_regs[i] = 64'd0;
    check_val("mid_rst_regs", cfg_regs, 256'd0);
    check_val("mid_rst_bsize", 256'(burst_size), 256'(0));
    check_val("mid_rst_update", 256'(config_update), 256'(0));
    check_val("mid_rst_resp", 256'({bus.wdone, bus.werr, bus.rvalid, bus.rerr}), 256'(0));
    check_val("mid_rst_rdata", 256'(bus.rdata), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_burst(8'd24, 1, 64'h0BAD_F00D, 64'd0, 64'd0, 64'd0, 0, 1'b0, 8'd0);
    do_read(8'd24);

    for (int i = 0; i < 20 && (wq.size() != 0 || rq.size() != 0); i++) @(negedge clk);
    check_val("scoreboard_drain", 256'(wq.size() + rq.size()), 256'(0));
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
